chunked_adder: RTL

- Parametrised multi-cycle adder/subtractor built from the team's full-adder arithmetic.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, carrying between chunks through a registered carry.
- Uses valid/ready handshakes on input and output. Sits between operand sources and accumulators where a full-width single-cycle carry chain would miss timing.

---
 rtl/chunked_adder_if.sv | 27 ++
 rtl/chunked_adder.sv | 90 +++++++++
 2 files changed

// File: rtl/chunked_adder_if.sv
// Handshake and operand/result bundle for chunked_adder.
// master = operand source / result consumer, slave = the adder.
interface chunked_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );
endinterface

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, LSB chunk first,
// with a registered carry between chunks. Subtract is a + ~b + ~cin.
module chunked_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  chunked_adder_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_chunk
      $error("chunked_adder: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             cout_q, ovf_q;

  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic [CHUNK:0]   chunk_d;
  logic             msb_cin_d;
  logic             last_d;
  int unsigned      base_d;

  // Current chunk add; carry into the top bit is recovered from the sum bit.
  always_comb begin
    base_d    = 32'(cnt_q) * 32'(CHUNK);
    a_chunk   = a_q[base_d +: CHUNK];
    b_chunk   = b_q[base_d +: CHUNK];
    chunk_d   = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    msb_cin_d = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_d[CHUNK-1];
    last_d    = (cnt_q == CW'(NCHUNK - 1));
  end

  // Control FSM with operand, carry and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.cin ^ bus.sub;
            cnt_q   <= '0;
            state_q <= ADD;
          end
        end
        ADD: begin
          sum_q[base_d +: CHUNK] <= chunk_d[CHUNK-1:0];
          carry_q                <= chunk_d[CHUNK];
          if (last_d) begin
            cout_q  <= chunk_d[CHUNK];
            ovf_q   <= msb_cin_d ^ chunk_d[CHUNK];
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;
endmodule
